// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// Parity polarity lives here so the receiver and any sibling stage agree.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  localparam int DATA_BITS_DEF = 3;
  localparam int ERRCNT_W_DEF  = 8;
  localparam bit PAR_EVEN      = 1'b1;

  // 1 = parity mismatch; for odd parity the sense inverts.
  function automatic logic parity_err(input logic data_xor, input logic par_bit);
    return data_xor ^ par_bit ^ ~PAR_EVEN;
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input stream plus the valid/ready output buffer of the frame receiver.
// master = producer/consumer side, slave = the receiver.
interface serial_frame_rx_if
  import serial_frame_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                 din;
  logic                 din_vld;
  logic                 sof;
  logic [DATA_BITS-1:0] out_word;
  logic                 out_perr;
  logic                 out_vld;
  logic                 out_rdy;

  modport master (
    output din, din_vld, sof, out_rdy,
    input  out_word, out_perr, out_vld
  );

  modport slave (
    input  din, din_vld, sof, out_rdy,
    output out_word, out_perr, out_vld
  );
endinterface

// File: rtl/serial_frame_rx_shift_acc.sv
// LSB-first deserializer with running XOR of the bits shifted in.
// clr together with shift_en starts a fresh frame with bit_in as bit 0.
module frame_shift_acc
  import serial_frame_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] sr,
  output logic                 acc
);

  logic [DATA_BITS-1:0] sr_base;
  logic [DATA_BITS-1:0] sr_shift;
  logic                 acc_base;

  assign sr_base  = clr ? '0 : sr;
  assign acc_base = clr ? 1'b0 : acc;

  // Right shift: after DATA_BITS shifts the first bit lands in bit 0.
  generate
    if (DATA_BITS == 1) begin : g_one
      assign sr_shift = bit_in;
    end else begin : g_many
      assign sr_shift = {bit_in, sr_base[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      acc <= 1'b0;
    end else if (clr || shift_en) begin
      sr  <= shift_en ? sr_shift : sr_base;
      acc <= acc_base ^ (shift_en & bit_in);
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: DATA_BITS data bits + parity -> word/perr via a 1-entry buffer.
// Define SERIAL_FRAME_RX_ERRCNT_EN to build the saturating parity-error counter.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ERRCNT_W  = ERRCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  serial_frame_rx_if.slave    bus,
  output logic                frm_abort,
  output logic                ovf,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int             CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                 clr, shift_en, abort_d, complete;
  logic [DATA_BITS-1:0] sr;
  logic                 acc;
  logic                 perr_new, load, drop;
  logic [DATA_BITS-1:0] word_q;
  logic                 perr_q, vld_q;

  frame_shift_acc #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (bus.din),
    .sr       (sr),
    .acc      (acc)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // sof restarts from any state; outside IDLE it also aborts the partial frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    abort_d  = 1'b0;
    complete = 1'b0;
    if (bus.din_vld) begin
      if (bus.sof) begin
        clr      = 1'b1;
        shift_en = 1'b1;
        cnt_d    = CNT_W'(1);
        state_d  = (DATA_BITS == 1) ? PAR : DATA;
        abort_d  = (state_q != IDLE);
      end else begin
        case (state_q)
          DATA: begin
            shift_en = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == CNT_LAST) state_d = PAR;
          end
          PAR: begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign perr_new = parity_err(acc, bus.din);
  assign load     = complete & (~vld_q | bus.out_rdy);
  assign drop     = complete & vld_q & ~bus.out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      perr_q    <= 1'b0;
      vld_q     <= 1'b0;
      frm_abort <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      frm_abort <= abort_d;
      if (drop) ovf <= 1'b1;
      if (load) begin
        word_q <= sr;
        perr_q <= perr_new;
        vld_q  <= 1'b1;
      end else if (vld_q && bus.out_rdy) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign bus.out_word = word_q;
  assign bus.out_perr = perr_q;
  assign bus.out_vld  = vld_q;

`ifdef SERIAL_FRAME_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q;

  // Only frames that enter the buffer are counted; dropped ones are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err_q <= '0;
    else if (load && perr_new && !(&err_q)) err_q <= err_q + 1'b1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: vector table, corner sequences, random frames.
module tb_serial_frame_rx;

  localparam int DB = 3;
  localparam int EW = 8;
`ifdef SERIAL_FRAME_RX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frm_abort, ovf;
  logic [EW-1:0] err_cnt;

  serial_frame_rx_if #(.DATA_BITS(DB)) bus ();

  serial_frame_rx #(.DATA_BITS(DB), .ERRCNT_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frm_abort (frm_abort),
    .ovf       (ovf),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DB-1:0] bits;     // bits[i] is the i-th data bit on the wire
    logic          par;
    int            gap;
    logic [DB-1:0] exp_word;
    logic          exp_perr;
  } vec_t;

  typedef struct {
    logic [DB-1:0] word;
    logic          perr;
  } frm_t;

  vec_t vt[7];
  frm_t exp_q[$];
  bit   mon_en = 1'b0;
  int   err_exp = 0;
  int   aborts_exp = 0;
  int   aborts_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    frm_t f;
    if (bus.out_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_unexpected_vld actual=1 expected=0 at %0t", $time);
      end else begin
        f = exp_q.pop_front();
        chk("rnd_word", 32'(bus.out_word), 32'(f.word));
        chk("rnd_perr", 32'(bus.out_perr), 32'(f.perr));
      end
    end
    if (frm_abort) aborts_seen++;
  endtask

  // Apply inputs for one clock; returns at the following falling edge.
  task automatic cyc(input logic v, input logic s, input logic d);
    bus.din_vld = v;
    bus.sof     = s;
    bus.din     = d;
    @(negedge clk);
    if (mon_en) monitor();
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(input logic [DB-1:0] bits, input logic par, input int gap);
    frm_t f;
    for (int i = 0; i <= DB; i++) begin
      repeat (gap) idle();
      if (i < DB) begin
        cyc(1'b1, (i == 0), bits[i]);
      end else begin
        if (mon_en) begin
          f.word = bits;
          f.perr = (^bits) ^ par;
          exp_q.push_back(f);
          if (f.perr && err_exp < 255) err_exp++;
        end
        cyc(1'b1, 1'b0, par);
      end
    end
  endtask

  task automatic chk_err(input string nm);
    chk(nm, 32'(err_cnt), ERRCNT_ON ? err_exp : 0);
  endtask

  initial begin
    vt[0] = '{bits: 3'b101, par: 1'b0, gap: 0, exp_word: 3'b101, exp_perr: 1'b0};
    vt[1] = '{bits: 3'b011, par: 1'b1, gap: 0, exp_word: 3'b011, exp_perr: 1'b1};
    vt[2] = '{bits: 3'b101, par: 1'b0, gap: 2, exp_word: 3'b101, exp_perr: 1'b0};
    vt[3] = '{bits: 3'b000, par: 1'b0, gap: 1, exp_word: 3'b000, exp_perr: 1'b0};
    vt[4] = '{bits: 3'b111, par: 1'b1, gap: 0, exp_word: 3'b111, exp_perr: 1'b0};
    vt[5] = '{bits: 3'b111, par: 1'b0, gap: 0, exp_word: 3'b111, exp_perr: 1'b1};
    vt[6] = '{bits: 3'b010, par: 1'b1, gap: 2, exp_word: 3'b010, exp_perr: 1'b0};

    rst = 1'b1;
    bus.din = 1'b0; bus.din_vld = 1'b0; bus.sof = 1'b0; bus.out_rdy = 1'b1;
    #1;
    chk("rst_word", 32'(bus.out_word), 0);
    chk("rst_vld",  32'(bus.out_vld),  0);
    chk("rst_perr", 32'(bus.out_perr), 0);
    chk("rst_ovf",  32'(ovf),          0);
    chk("rst_abort",32'(frm_abort),    0);
    chk("rst_err",  32'(err_cnt),      0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("post_rst_vld", 32'(bus.out_vld), 0);

    // Table-driven frames, out_rdy held high.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < DB; i++) begin
        repeat (vt[t].gap) idle();
        cyc(1'b1, (i == 0), vt[t].bits[i]);
      end
      repeat (vt[t].gap) idle();
      chk($sformatf("tbl%0d_pre_vld", t), 32'(bus.out_vld), 0);
      cyc(1'b1, 1'b0, vt[t].par);
      if (vt[t].exp_perr) err_exp++;
      chk($sformatf("tbl%0d_vld", t),   32'(bus.out_vld),  1);
      chk($sformatf("tbl%0d_word", t),  32'(bus.out_word), 32'(vt[t].exp_word));
      chk($sformatf("tbl%0d_perr", t),  32'(bus.out_perr), 32'(vt[t].exp_perr));
      chk($sformatf("tbl%0d_abort", t), 32'(frm_abort),    0);
      idle();
      chk($sformatf("tbl%0d_drop", t),  32'(bus.out_vld),  0);
    end
    chk_err("tbl_err_cnt");

    // Early sof: partial 1,1 then restart with 0,0,1 / parity 1.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("es_abort_pre", 32'(frm_abort), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("es_abort_pulse", 32'(frm_abort), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("es_abort_clear", 32'(frm_abort), 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("es_vld",   32'(bus.out_vld),  1);
    chk("es_word",  32'(bus.out_word), 32'(3'b100));
    chk("es_perr",  32'(bus.out_perr), 0);
    chk("es_abort_end", 32'(frm_abort), 0);
    idle();

    // Completion coinciding with handshake: no bubble, new word loaded.
    bus.out_rdy = 1'b0;
    send_frame(3'b001, 1'b1, 0);
    chk("nb_first_word", 32'(bus.out_word), 32'(3'b001));
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("nb_held", 32'(bus.out_word), 32'(3'b001));
    bus.out_rdy = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("nb_vld",  32'(bus.out_vld),  1);
    chk("nb_word", 32'(bus.out_word), 32'(3'b110));
    chk("nb_ovf",  32'(ovf),          0);
    idle();
    chk("nb_drop", 32'(bus.out_vld), 0);

    // Backpressure: second back-to-back frame is dropped, ovf sticks.
    bus.out_rdy = 1'b0;
    send_frame(3'b101, 1'b0, 0);
    chk("bp_first_vld", 32'(bus.out_vld), 1);
    chk("bp_ovf_pre",   32'(ovf),         0);
    send_frame(3'b011, 1'b0, 0);
    chk("bp_ovf",      32'(ovf),          1);
    chk("bp_vld",      32'(bus.out_vld),  1);
    chk("bp_word",     32'(bus.out_word), 32'(3'b101));
    idle();
    chk("bp_hold",     32'(bus.out_word), 32'(3'b101));
    bus.out_rdy = 1'b1;
    idle();
    chk("bp_single_hs", 32'(bus.out_vld), 0);
    chk("bp_ovf_stick", 32'(ovf),         1);
    idle();
    chk("bp_no_second", 32'(bus.out_vld), 0);
    chk_err("bp_err_cnt");

    // Asynchronous reset mid-frame, between clock edges.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_word",  32'(bus.out_word), 0);
    chk("ar_vld",   32'(bus.out_vld),  0);
    chk("ar_ovf",   32'(ovf),          0);
    chk("ar_abort", 32'(frm_abort),    0);
    chk("ar_err",   32'(err_cnt),      0);
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
    idle();
    send_frame(3'b011, 1'b0, 0);
    chk("ar_new_vld",   32'(bus.out_vld),  1);
    chk("ar_new_word",  32'(bus.out_word), 32'(3'b011));
    chk("ar_new_perr",  32'(bus.out_perr), 0);
    chk("ar_new_abort", 32'(frm_abort),    0);
    idle();

    // Random frames with gaps and aborted partials, checked by the queue model.
    mon_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int len;
        len = $urandom_range(1, DB);
        for (int k = 0; k < len; k++) begin
          repeat ($urandom_range(0, 1)) idle();
          cyc(1'b1, (k == 0), 1'($urandom));
        end
        aborts_exp++;
      end
      send_frame(DB'($urandom), 1'($urandom), $urandom_range(0, 2));
    end
    repeat (3) idle();
    mon_en = 1'b0;
    chk("rnd_queue_empty", 32'(exp_q.size()), 0);
    chk("rnd_aborts",      32'(aborts_seen),  32'(aborts_exp));
    chk("rnd_ovf",         32'(ovf),          0);
    chk_err("rnd_err_cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 3-bit serial parity stage.
- Takes a serial bit stream framed as DATA_BITS data bits followed by one even-parity bit, and deserializes each frame into a parallel word.
- Checks parity and presents word + error flag through a 1-entry valid/ready output buffer.
- Feeds the parallel-side logic that follows the serial front end.

Parameters:
- DATA_BITS, 3, data bits per frame (parity bit excluded); legal range 1..16.
- ERRCNT_W, 8, width of the optional parity-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_vld  in  1  din valid this cycle; cycles with din_vld=0 are ignored.
- sof  in  1  start-of-frame; qualified by din_vld; marks din as data bit 0.
- out_word  out  DATA_BITS  deserialized data word.
- out_perr  out  1  parity mismatch for out_word.
- out_vld  out  1  output buffer holds a frame.
- out_rdy  in  1  consumer accepts when out_vld & out_rdy.
- frm_abort  out  1  one-cycle pulse: frame aborted by early sof.
- ovf  out  1  sticky: completed frame dropped because buffer full.
- err_cnt  out  ERRCNT_W  parity-error count (optional feature).

Behaviour:
- Reset is asynchronous, active-high. While rst=1 and after release:
  - FSM = IDLE, bit counter = 0, shift register = 0.
  - out_word=0, out_perr=0, out_vld=0, frm_abort=0, ovf=0, err_cnt=0.
- Reset mid-frame discards the partial frame and any buffered word.
- FSM states: IDLE, DATA, PAR.
  - IDLE: din_vld & sof -> load din into bit 0, cnt=1; go to DATA, or PAR if DATA_BITS=1. din_vld without sof is ignored.
  - DATA: each din_vld & ~sof shifts din into bit position cnt (LSB first) and increments cnt. When cnt reaches DATA_BITS, go to PAR.
  - PAR: din_vld & ~sof samples the parity bit and completes the frame, then go to IDLE.
  - Any state: din_vld=0 holds all state.
- Running parity: XOR of the data bits. perr = running_xor XOR parity_bit (even parity, so 0 = good).
- Early sof: din_vld & sof in DATA or PAR:
  - Pulse frm_abort for one cycle, registered, on the next cycle.
  - Discard the partial frame.
  - Restart with din as bit 0, same transition as from IDLE.
- Completion latency: the frame completes at the clock edge that samples the parity bit. out_vld=1 from the next cycle, with out_word/out_perr stable.
- Output buffer:
  - Holds its contents while out_vld & ~out_rdy.
  - out_vld drops the cycle after the handshake unless a new frame completes in the same cycle.
- Simultaneous completion and handshake (out_vld & out_rdy at the completion edge): load the new frame; out_vld stays 1 with no bubble.
- Completion while full (out_vld & ~out_rdy): the new frame is dropped, the buffer is unchanged, and ovf is set and held until reset. The FSM still returns to IDLE.
- Back-to-back frames: sof may be asserted in the cycle immediately after the parity bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERIAL_FRAME_RX_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each completed frame with perr=1 that is loaded into the buffer; dropped frames are not counted.
  - err_cnt saturates at 2^ERRCNT_W-1.
- Undefined: err_cnt is tied to 0 and no counter flops are generated. The port list is identical in both builds.

Decomposition:
- Package serial_frame_pkg:
  - FSM state typedef {IDLE, DATA, PAR}.
  - Default constants DATA_BITS_DEF=3 and ERRCNT_W_DEF=8.
  - Parity polarity constant PAR_EVEN=1.
- Sub-module frame_shift_acc: DATA_BITS-wide LSB-first shift register plus XOR accumulator, with clear and shift enables. Instantiated once.
- FSM and output buffer live in serial_frame_rx.

Test Plan:
- Good frame, DATA_BITS=3, out_rdy=1: sof with bits 1,0,1 then parity 0 -> out_word=3'b101, out_perr=0, out_vld high exactly 1 cycle after the parity edge.
- Bad parity: bits 1,1,0 then parity 1 -> out_word=3'b011, out_perr=1; with ERRCNT_EN, err_cnt 0->1.
- Gaps: same good frame with din_vld=0 for 2 cycles between each bit -> identical result, no frm_abort.
- Early sof: sof, 1, 1, then sof with bits 0,0,1 and parity 1 -> frm_abort pulses once; out_word=3'b100, out_perr=0.
- Backpressure: out_rdy=0, two back-to-back good frames -> first word held, ovf=1 after second parity edge; raising out_rdy gives a single handshake of the first word, and ovf remains 1.
- Async reset asserted mid-DATA, between clock edges -> all outputs 0 immediately; next sof frame received correctly after release.
